fifo_core: RTL and testbench

FIFO_CORE -- requirements
Module: fifo_core

---
 rtl/fifo_core.sv | 90 +++++++++
 tb/tb_fifo_core.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_core.sv
// Single-clock synchronous FIFO with registered read data, occupancy/threshold
// flags decoded from a registered count, and sticky overflow/underflow errors.
module fifo_core #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    clr_err,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AFULL_TH);
  localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_TH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  always_comb begin
    // A full FIFO still takes a write when a read frees the slot this cycle.
    wr_acc       = wr_en && (!full || rd_en);
    rd_acc       = rd_en && !empty;
    wr_ptr_d     = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d      = count_q;
    if (wr_acc && !rd_acc) count_d = count_q + 1'b1;
    if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
    data_out_d   = rd_acc ? mem_q[rd_ptr_q] : data_out_q;
    data_valid_d = rd_acc;
    // A new error in the same cycle as clr_err wins.
    overflow_d   = (overflow_q  && !clr_err) || (wr_en && full && !rd_en);
    underflow_d  = (underflow_q && !clr_err) || (rd_en && empty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage is not reset; the pointers alone define which words are live.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
endmodule

// File: tb/tb_fifo_core.sv
// Self-checking bench for fifo_core: a queue-based reference model is stepped
// alongside the DUT and each scenario task compares outputs against it.
module tb_fifo_core;
  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] data_in, data_out;
  logic       data_valid, full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] m_dout = 8'h00;
  logic       m_dv = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

  fifo_core #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .clr_err(clr_err), .data_out(data_out), .data_valid(data_valid),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the model applies the FIFO rules to its queue.
  task automatic cycle(input logic we, input logic re, input logic clr, input logic [7:0] d);
    int n;
    n = q.size();
    wr_en = we; rd_en = re; clr_err = clr; data_in = d;
    @(posedge clk);
    m_ovf = (m_ovf && !clr) || (we && n == 16 && !re);
    m_unf = (m_unf && !clr) || (re && n == 0);
    m_dv  = re && n != 0;
    if (m_dv) m_dout = q.pop_front();
    if (we && (n < 16 || re)) q.push_back(d);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({full, empty, almost_full, almost_empty, overflow, underflow, data_valid} !== 7'b0101000) begin
      errors++; $display("FAIL reset_flags got %b exp 0101000",
        {full, empty, almost_full, almost_empty, overflow, underflow, data_valid});
    end
    checks++;
    if ({count, data_out} !== 13'h0) begin
      errors++; $display("FAIL reset_count_dout got count=%0d dout=%0h exp 0/0", count, data_out);
    end
  endtask

  task automatic test_basic;
    logic [7:0] exp [3];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, exp[i]);
    checks++;
    if (count !== 5'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", count); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 8'h00);
      checks++;
      if (data_valid !== 1'b1 || data_out !== exp[i]) begin
        errors++; $display("FAIL basic_read%0d got dv=%b dout=%0h exp 1/%0h", i, data_valid, data_out, exp[i]);
      end
      checks++;
      if (count !== 5'(2 - i)) begin errors++; $display("FAIL basic_cnt%0d got %0d exp %0d", i, count, 2 - i); end
    end
    cycle(0, 0, 0, 8'h00);
    checks++;
    if (empty !== 1'b1 || data_valid !== 1'b0 || data_out !== 8'h33) begin
      errors++; $display("FAIL basic_end got empty=%b dv=%b dout=%0h exp 1/0/33", empty, data_valid, data_out);
    end
  endtask

  task automatic test_full_overflow;
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 8'(i));
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
      errors++; $display("FAIL full_set got full=%b count=%0d ovf=%b exp 1/16/0", full, count, overflow);
    end
    cycle(1, 0, 0, 8'hAA);
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      errors++; $display("FAIL overflow got ovf=%b count=%0d exp 1/16", overflow, count);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 0, 8'h00);
      checks++;
      if (data_valid !== 1'b1 || data_out !== 8'(i) || data_out !== m_dout) begin
        errors++; $display("FAIL drain%0d got dv=%b dout=%0h exp 1/%0h", i, data_valid, data_out, i);
      end
    end
    cycle(0, 0, 1, 8'h00);
    checks++;
    if (overflow !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL ovf_clear got ovf=%b empty=%b exp 0/1", overflow, empty);
    end
  endtask

  task automatic test_full_simul;
    logic [7:0] head, last;
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 8'($urandom));
    head = q[0];
    cycle(1, 1, 0, 8'h55);
    checks++;
    if (data_valid !== 1'b1 || data_out !== head || count !== 5'd16 || overflow !== 1'b0) begin
      errors++; $display("FAIL full_rw got dv=%b dout=%0h cnt=%0d ovf=%b exp 1/%0h/16/0",
        data_valid, data_out, count, overflow, head);
    end
    last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 0, 8'h00);
      checks++;
      if (data_out !== m_dout) begin errors++; $display("FAIL full_rw_drain%0d got %0h exp %0h", i, data_out, m_dout); end
      last = data_out;
    end
    checks++;
    if (last !== 8'h55 || empty !== 1'b1) begin
      errors++; $display("FAIL full_rw_last got %0h empty=%b exp 55/1", last, empty);
    end
  endtask

  task automatic test_underflow;
    logic [7:0] held;
    held = data_out;
    cycle(0, 1, 0, 8'h00);
    checks++;
    if (underflow !== 1'b1 || data_valid !== 1'b0 || data_out !== held) begin
      errors++; $display("FAIL underflow got unf=%b dv=%b dout=%0h exp 1/0/%0h", underflow, data_valid, data_out, held);
    end
    cycle(0, 1, 1, 8'h00);
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL clr_vs_err got %b exp 1", underflow); end
    cycle(0, 0, 1, 8'h00);
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clear got %b exp 0", underflow); end
    cycle(1, 1, 0, 8'h9C);
    checks++;
    if (count !== 5'd1 || underflow !== 1'b1 || data_valid !== 1'b0) begin
      errors++; $display("FAIL empty_rw got cnt=%0d unf=%b dv=%b exp 1/1/0", count, underflow, data_valid);
    end
    cycle(0, 1, 1, 8'h00);
    checks++;
    if (data_out !== 8'h9C || underflow !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL empty_rw_read got dout=%0h unf=%b empty=%b exp 9c/0/1", data_out, underflow, empty);
    end
  endtask

  task automatic test_random_wrap;
    int wrs = 0, rds = 0, cyc = 0, n;
    logic we, re;
    while ((wrs < 20 || rds < 20) && cyc < 600) begin
      we = (wrs < 20) && ($urandom_range(0, 9) < 7);
      re = (rds < 20) && ($urandom_range(0, 9) < ((wrs < 20) ? 1 : 6));
      n = q.size();
      if (we && (n < 16 || re)) wrs++;
      if (re && n > 0) rds++;
      cycle(we, re, 0, 8'($urandom));
      cyc++;
      checks++;
      if (data_valid !== m_dv || (m_dv && data_out !== m_dout)) begin
        errors++; $display("FAIL rnd_data c%0d got dv=%b dout=%0h exp %b/%0h", cyc, data_valid, data_out, m_dv, m_dout);
      end
      checks++;
      if (count !== 5'(q.size()) || full !== (q.size() == 16) || empty !== (q.size() == 0)) begin
        errors++; $display("FAIL rnd_count c%0d got %0d f=%b e=%b exp %0d", cyc, count, full, empty, q.size());
      end
      checks++;
      if (almost_full !== (q.size() >= 14) || almost_empty !== (q.size() <= 2)) begin
        errors++; $display("FAIL rnd_thresh c%0d got af=%b ae=%b at count %0d", cyc, almost_full, almost_empty, q.size());
      end
      checks++;
      if (overflow !== m_ovf || underflow !== m_unf) begin
        errors++; $display("FAIL rnd_err c%0d got ovf=%b unf=%b exp %b/%b", cyc, overflow, underflow, m_ovf, m_unf);
      end
    end
    checks++;
    if (cyc >= 600) begin errors++; $display("FAIL rnd_timeout got %0d writes %0d reads exp 20/20", wrs, rds); end
    cycle(0, 0, 1, 8'h00);
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 8'(8'hA0 + i));
    cycle(0, 1, 0, 8'h00);
    checks++;
    if (data_out !== 8'hA0 || data_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset got dout=%0h dv=%b exp a0/1", data_out, data_valid);
    end
    #2 rst = 1'b0;
    #1;
    q.delete(); m_dout = 8'h00; m_dv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    checks++;
    if ({count, data_out} !== 13'h0 ||
        {full, empty, almost_full, almost_empty, overflow, underflow, data_valid} !== 7'b0101000) begin
      errors++; $display("FAIL async_reset got cnt=%0d dout=%0h flags=%b exp 0/0/0101000", count, data_out,
        {full, empty, almost_full, almost_empty, overflow, underflow, data_valid});
    end
    #1 rst = 1'b1;
    cycle(0, 1, 0, 8'h00);
    checks++;
    if (underflow !== 1'b1 || data_valid !== 1'b0 || data_out !== 8'h00) begin
      errors++; $display("FAIL post_reset_read got unf=%b dv=%b dout=%0h exp 1/0/0", underflow, data_valid, data_out);
    end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = 8'h00;
    #12;
    test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    test_basic;
    test_full_overflow;
    test_full_simul;
    test_underflow;
    test_random_wrap;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
